// File: rtl/irq_event_source.sv
// Interrupt requester for the LEGv8 core: timer/trigger events are queued in a
// saturating counter and presented one at a time over a four-phase ExtIRQ/ExtIAck handshake.
module irq_event_source #(
    parameter int PERIOD = 100,
    parameter int PEND_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              timer_en,
    input  logic              trigger,
    input  logic              ExtIAck,
    output logic              ExtIRQ,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  serviced,
    output logic              overrun,
    output logic              busy
);
    localparam int TW = $clog2(PERIOD);
    localparam logic [TW-1:0]     TMAX = TW'(PERIOD - 1);
    localparam logic [PEND_W+1:0] PMAX = {2'b00, {PEND_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACKED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       count_q, count_d;
    logic                trig_q;
    logic [PEND_W-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]    serviced_q, serviced_d;
    logic                overrun_q, overrun_d;
    logic                irq_q;
    logic                busy_q;
    logic                tick_s;
    logic                edge_s;
    logic                dec_s;
    logic [PEND_W+1:0]   sum_s;

    // Handshake sequencing; only an ack seen in REQ consumes a pending event
    always_comb begin
        state_d = state_q;
        dec_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q != {PEND_W{1'b0}}) state_d = REQ;
                else                             state_d = IDLE;
            end
            REQ: begin
                if (ExtIAck) begin
                    state_d = ACKED;
                    dec_s   = 1'b1;
                end else begin
                    state_d = REQ;
                end
            end
            ACKED: begin
                if (!ExtIAck) state_d = IDLE;
                else          state_d = ACKED;
            end
            default: state_d = IDLE;
        endcase
    end

    // Timer, edge detection and saturating event accounting
    always_comb begin
        count_d = count_q;
        if (timer_en) begin
            if (count_q == TMAX) count_d = {TW{1'b0}};
            else                 count_d = count_q + TW'(1);
        end else begin
            count_d = count_q;
        end
        tick_s = timer_en && (count_q == TMAX);
        edge_s = trigger && !trig_q;
        // pending is nonzero whenever dec_s fires, so this cannot underflow
        sum_s  = {2'b00, pending_q} + (PEND_W+2)'(tick_s) + (PEND_W+2)'(edge_s)
               - (PEND_W+2)'(dec_s);
        if (sum_s > PMAX) begin
            pending_d = PMAX[PEND_W-1:0];
            overrun_d = 1'b1;
        end else begin
            pending_d = sum_s[PEND_W-1:0];
            overrun_d = overrun_q;
        end
        if (dec_s) serviced_d = serviced_q + CNT_W'(1);
        else       serviced_d = serviced_q;
    end

    // State and counter registers; ExtIRQ/busy are registered decodes of the next state
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= {TW{1'b0}};
            trig_q     <= 1'b0;
            pending_q  <= {PEND_W{1'b0}};
            serviced_q <= {CNT_W{1'b0}};
            overrun_q  <= 1'b0;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            trig_q     <= trigger;
            pending_q  <= pending_d;
            serviced_q <= serviced_d;
            overrun_q  <= overrun_d;
            irq_q      <= (state_d == REQ);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign ExtIRQ   = irq_q;
    assign pending  = pending_q;
    assign serviced = serviced_q;
    assign overrun  = overrun_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_irq_event_source.sv
// Randomized scoreboard bench for irq_event_source against an event-count model.
module tb_irq_event_source;
    localparam int PERIOD = 10;
    localparam int PEND_W = 3;
    localparam int CNT_W  = 4;
    localparam int PMAX   = (1 << PEND_W) - 1;
    localparam int SMOD   = 1 << CNT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ten = 1'b0;
    logic              trg = 1'b0;
    logic              ack = 1'b0;
    logic              irq;
    logic [PEND_W-1:0] pend;
    logic [CNT_W-1:0]  serv;
    logic              ovr;
    logic              bsy;

    irq_event_source #(.PERIOD(PERIOD), .PEND_W(PEND_W), .CNT_W(CNT_W)) dut (
        .CLOCK_50(clk), .reset(rst), .timer_en(ten), .trigger(trg), .ExtIAck(ack),
        .ExtIRQ(irq), .pending(pend), .serviced(serv), .overrun(ovr), .busy(bsy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit irq;
        int pend;
        int serv;
        bit ovr;
        bit busy;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;

    // Reference model: timer position, last trigger level, handshake phase
    // (0 waiting, 1 requesting, 2 waiting for ack release) and event counts.
    int m_cnt, m_trig, m_pend, m_serv, m_phase;
    bit m_ovr;
    bit ack_r;
    int ack_wait;

    task automatic model_reset();
        m_cnt = 0; m_trig = 0; m_pend = 0; m_serv = 0; m_phase = 0; m_ovr = 1'b0;
        ack_r = 1'b0; ack_wait = 0;
    endtask

    task automatic model_step(input bit t_en, input bit tr, input bit ak);
        int   events, dec, total;
        exp_t x;
        events = 0;
        dec    = 0;
        if (t_en && m_cnt == PERIOD - 1) events++;
        if (t_en) m_cnt = (m_cnt + 1) % PERIOD;
        if (tr && m_trig == 0) events++;
        m_trig = tr ? 1 : 0;
        if (m_phase == 0) begin
            if (m_pend > 0) m_phase = 1;
        end else if (m_phase == 1) begin
            if (ak) begin
                dec = 1;
                m_phase = 2;
            end
        end else begin
            if (!ak) m_phase = 0;
        end
        total = m_pend + events - dec;
        if (total > PMAX) begin
            total = PMAX;
            m_ovr = 1'b1;
        end
        m_pend = total;
        m_serv = (m_serv + dec) % SMOD;
        x.irq  = (m_phase == 1);
        x.pend = m_pend;
        x.serv = m_serv;
        x.ovr  = m_ovr;
        x.busy = (m_phase != 0);
        sb.push_back(x);
    endtask

    // Monitor: compare DUT outputs with the oldest queued expectation
    always @(negedge clk) begin
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (irq !== e.irq || pend !== PEND_W'(e.pend) || serv !== CNT_W'(e.serv) ||
                ovr !== e.ovr || bsy !== e.busy) begin
                failed++;
                $display("FAIL outputs cycle %0d: got irq=%0b pend=%0d serv=%0d ovr=%0b busy=%0b, want irq=%0b pend=%0d serv=%0d ovr=%0b busy=%0b",
                         cyc, irq, pend, serv, ovr, bsy, e.irq, e.pend, e.serv, e.ovr, e.busy);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            failed++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ExtIRQ"},   int'(irq),  0);
        check({tag, " pending"},  int'(pend), 0);
        check({tag, " serviced"}, int'(serv), 0);
        check({tag, " overrun"},  int'(ovr),  0);
        check({tag, " busy"},     int'(bsy),  0);
    endtask

    task automatic step(input bit t_en, input bit tr, input bit ak);
        @(negedge clk);
        #1;
        ten = t_en;
        trg = tr;
        ack = ak;
        model_step(t_en, tr, ak);
    endtask

    // Async reset applied mid-cycle; outputs must clear before any clock edge
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        trg = 1'b0;
        ack = 1'b0;
        #1;
        check_reset_outputs("async reset");
        sb.delete();
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // tmode: 0 low, 1 high, 2 toggling every 2 cycles, 3 random.
    // The core side acks ack_dly cycles into a request and releases ack_hold cycles later.
    task automatic auto_run(input int n, input bit t_en, input int tmode,
                            input int ack_dly, input int ack_hold);
        bit tr;
        for (int i = 0; i < n; i++) begin
            case (tmode)
                0:       tr = 1'b0;
                1:       tr = 1'b1;
                2:       tr = i[1];
                default: tr = 1'($urandom_range(0, 1));
            endcase
            if (m_phase == 1 && !ack_r) begin
                if (ack_wait >= ack_dly) begin ack_r = 1'b1; ack_wait = 0; end
                else ack_wait++;
            end else if (m_phase == 2 && ack_r) begin
                if (ack_wait >= ack_hold) begin ack_r = 1'b0; ack_wait = 0; end
                else ack_wait++;
            end else begin
                ack_wait = 0;
            end
            step(t_en, tr, ack_r);
        end
    endtask

    task automatic rand_run(input int n);
        bit t_en, tr, ak;
        for (int i = 0; i < n; i++) begin
            t_en = ($urandom_range(0, 7) != 0);
            tr   = ($urandom_range(0, 3) == 0);
            ak   = ($urandom_range(0, 2) != 0);
            step(t_en, tr, ak);
        end
    endtask

    initial begin
        model_reset();
        #3;
        check_reset_outputs("power-on reset");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // quiet period, then a single held trigger
        auto_run(50, 1'b0, 0, 1000, 0);
        auto_run(10, 1'b0, 1, 3, 2);
        auto_run(20, 1'b0, 0, 3, 2);

        // periodic timer serviced within a few cycles
        auto_run(60, 1'b1, 0, 2, 1);
        auto_run(10, 1'b0, 0, 2, 1);

        // saturation with ack held low, then drain
        auto_run(32, 1'b0, 2, 1000, 0);
        auto_run(60, 1'b0, 0, 1, 1);

        // reset while requesting with two events queued
        auto_run(8, 1'b0, 2, 1000, 0);
        do_reset();
        auto_run(50, 1'b0, 0, 1000, 0);

        // ack held high long after acknowledgement with events still queued
        auto_run(12, 1'b0, 2, 1000, 0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);

        // random traffic: simultaneous events, stray acks, serviced wrap
        do_reset();
        rand_run(3000);
        auto_run(80, 1'b0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Time limit guard
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/irq_event_source.md
Name: irq_event_source

Overview:
- Generates the external interrupt request `ExtIRQ` consumed by the exception-capable LEGv8 pipeline (`processor_arm`).
- Acts as the device/requester end of the `ExtIRQ`/`ExtIAck` handshake.
- Events come from an internal periodic timer or a manual trigger input. They are queued in a saturating pending counter and presented to the core one at a time, using a four-phase request/acknowledge protocol.
- Sits beside `processor_arm` in the top level and in the processor testbench, replacing hand-driven `ExtIRQ` stimulus.

Parameters:
- PERIOD, 100, timer tick interval in clock cycles (≥2).
- PEND_W, 3, width of pending-event counter; saturates at 2^PEND_W-1.
- CNT_W, 16, width of serviced-interrupt counter.

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- timer_en  input  1  enables the periodic timer.
- trigger  input  1  manual event source; a rising edge (0→1 between consecutive clock samples) is one event.
- ExtIAck  input  1  acknowledge from the core's exception unit.
- ExtIRQ  output  1  interrupt request to the core; registered.
- pending  output  PEND_W  events queued and not yet acknowledged.
- serviced  output  CNT_W  count of completed handshakes; wraps modulo 2^CNT_W.
- overrun  output  1  sticky flag: an event arrived while pending was saturated.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (async, immediate, any state):
  - ExtIRQ=0, pending=0, serviced=0, overrun=0, busy=0.
  - timer count=0, trigger sample register=0, FSM=IDLE.
- Timer:
  - Counts 0..PERIOD-1 while timer_en=1, then wraps to 0.
  - The cycle with count==PERIOD-1 and timer_en=1 produces one tick event.
  - timer_en=0 holds the count; it does not clear it.
- Trigger: edge detected against a one-cycle registered copy. Holding trigger high gives exactly one event.
- Event accounting per clock:
  - ev = tick + trig_edge (0, 1 or 2 events).
  - dec = 1 on the cycle the FSM takes REQ→ACKED.
  - pending_next = min(pending + ev - dec, MAX), where MAX = 2^PEND_W-1.
  - If pending + ev - dec > MAX, overrun is set (sticky until reset).
  - Simultaneous tick + edge with pending=MAX-1 and no dec: pending becomes MAX and overrun is set.
  - Simultaneous event and dec: net arithmetic as above; no event is lost.
- FSM, states IDLE, REQ, ACKED:
  - IDLE: ExtIRQ=0. If pending>0 (registered value), go to REQ next edge.
  - REQ: ExtIRQ=1, held steady until ExtIAck=1 is sampled.
    - On that edge go to ACKED, decrement pending, and increment serviced.
    - If ExtIAck is already 1 on REQ entry, it still counts as acknowledgment on the first REQ cycle.
  - ACKED: ExtIRQ=0. Wait for ExtIAck=0, then go to IDLE.
    - A request is never reissued while ExtIAck stays high (four-phase protocol).
- ExtIRQ is a decode of the registered state: 1 only in REQ.
- Latency from the first event to ExtIRQ=1:
  - Event at edge k sets pending=1 at edge k.
  - The FSM enters REQ at edge k+1, so ExtIRQ is high after edge k+1.
- ExtIRQ falls on the same edge that samples ExtIAck=1.
- Back-to-back requests need at least one IDLE cycle between ACKED and the next REQ.
- busy = (state != IDLE).
- serviced wraps from 2^CNT_W-1 to 0 without a flag.
- ExtIAck pulses while in IDLE or ACKED (other than deassertion) are ignored. They have no effect on counters.

Test Plan:
- Reset behaviour: assert reset mid-REQ with pending=2 → same cycle, asynchronously: ExtIRQ=0, pending=0, serviced=0, busy=0. After release with no events, ExtIRQ stays 0 for 50 cycles.
- Manual trigger handshake: trigger 0→1 held high for 10 cycles, ExtIAck raised 3 cycles after ExtIRQ rises and dropped 2 cycles later → exactly one request; ExtIRQ high 2 cycles after the edge; serviced=1; pending=0; FSM back in IDLE.
- Periodic timer: PERIOD=10, timer_en=1, core acks each request within 4 cycles → ExtIRQ rising edges exactly 10 cycles apart; serviced=5 after 5 ticks; overrun=0.
- Saturation: PEND_W=3, ExtIAck held 0, eight trigger edges → pending=7, overrun=1, ExtIRQ held high throughout. Then 7 full handshakes → serviced=7, pending=0.
- Simultaneous events: tick and trigger edge on the same cycle as an ack, with pending=1 → pending=2, serviced increments by 1, next REQ issued after the ACKED→IDLE transition.
- Four-phase rule: ExtIAck held high for 20 cycles after ack with pending=3 → ExtIRQ stays 0 until 2 cycles after ExtIAck falls; pending=2 during the hold.
